// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns the byte stream from the SPI slave shift stage into
// DDS control registers (frequency word, phase offset, enable). It also feeds
// readback bytes to the slave through its parallel-load path. Committed values
// change only on a clean frame end, which is marked by a one-clk update pulse.
module spi_cmd_decoder #(
  parameter int           B  = 8,
  parameter int           FW = 32,
  parameter int           PW = 16,
  parameter logic [B-1:0] ID = 8'hD5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ss,
  input  logic          br,
  input  logic [B-1:0]  spi_byte,
  output logic          spi_load,
  output logic [B-1:0]  spi_wordin,
  output logic [FW-1:0] freq_word,
  output logic [PW-1:0] phase_word,
  output logic          enable,
  output logic          update,
  output logic          frame_err
);

  localparam int MW = (FW > PW) ? FW : PW;
  localparam int NF = FW / B;
  localparam int NP = PW / B;
  localparam int NB = MW / B;
  localparam int CW = $clog2(NB + 1) + 1;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] rdidx, rdidx_n;
  logic [MW-1:0] shadow, shadow_n;
  logic          err, err_n;
  logic [1:0]    addr, addr_n;
  logic          commit, ferr;

  logic ss_s1, ss_s2, ss_d;
  logic br_s1, br_s2, br_d;
  logic v1, v2, armed;
  logic ss_fall, ss_rise, byte_ev;

  logic [MW-1:0] sel_val;
  logic [CW-1:0] sel_len;
  logic          rd_valid;
  int            rd_pos;
  logic [B-1:0]  rd_byte;

  // Falling edges count only once ss has been seen high with real samples.
  // A reset released mid-frame therefore sits in IDLE until that frame ends.
  assign ss_fall = armed & ss_d & ~ss_s2;
  assign ss_rise = ~ss_d & ss_s2;
  assign byte_ev = br_s2 & ~br_d & ~ss_s2;

  // Two-flop synchronisers for ss and br, edge history, and the arming flag.
  // br history is forced high when a frame starts, so the slave's idle br=1
  // is not mistaken for a completed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1 <= 1'b1;
      ss_s2 <= 1'b1;
      ss_d  <= 1'b1;
      br_s1 <= 1'b1;
      br_s2 <= 1'b1;
      br_d  <= 1'b1;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      ss_s1 <= ss;
      ss_s2 <= ss_s1;
      ss_d  <= ss_s2;
      br_s1 <= br;
      br_s2 <= br_s1;
      br_d  <= ss_fall ? 1'b1 : br_s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & ss_s2);
    end
  end

  // Select the committed register being read back and pick the current byte, MSB first.
  always_comb begin
    sel_val = '0;
    sel_len = '0;
    case (addr)
      2'd0: begin
        sel_val[FW-1:0] = freq_word;
        sel_len = CW'(NF);
      end
      2'd1: begin
        sel_val[PW-1:0] = phase_word;
        sel_len = CW'(NP);
      end
      2'd2: begin
        sel_val[0] = enable;
        sel_len = CW'(1);
      end
      default: begin
        sel_val[B-1:0] = ID;
        sel_len = CW'(1);
      end
    endcase
    rd_valid = (rdidx < sel_len);
    rd_pos   = rd_valid ? (int'(sel_len) - 1 - int'(rdidx)) : 0;
    rd_byte  = '0;
    for (int k = 0; k < NB; k++) begin
      if (rd_valid && rd_pos == k) rd_byte = sel_val[k*B +: B];
    end
  end

  // Frame FSM state register with its shadow, byte count, address and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rdidx  <= '0;
      shadow <= '0;
      err    <= 1'b0;
      addr   <= 2'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rdidx  <= rdidx_n;
      shadow <= shadow_n;
      err    <= err_n;
      addr   <= addr_n;
    end
  end

  // Next state: handle a byte first, then judge frame end on the updated state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rdidx_n  = rdidx;
    shadow_n = shadow;
    err_n    = err;
    addr_n   = addr;
    commit   = 1'b0;
    ferr     = 1'b0;
    if (byte_ev) begin
      case (state)
        CMD: begin
          addr_n = spi_byte[1:0];
          if (spi_byte[B-1]) begin
            if (spi_byte[1:0] == 2'd3) begin
              state_n = DRAIN;
              err_n   = 1'b1;
            end else begin
              state_n  = WDATA;
              shadow_n = '0;
              case (spi_byte[1:0])
                2'd0:    cnt_n = CW'(NF);
                2'd1:    cnt_n = CW'(NP);
                default: cnt_n = CW'(1);
              endcase
            end
          end else begin
            state_n = RDATA;
            rdidx_n = '0;
          end
        end
        WDATA: begin
          if (cnt == '0) begin
            err_n   = 1'b1;
            state_n = DRAIN;
          end else begin
            shadow_n = {shadow[MW-B-1:0], spi_byte};
            cnt_n    = cnt - CW'(1);
          end
        end
        RDATA: begin
          if (rd_valid) rdidx_n = rdidx + CW'(1);
        end
        default: ;
      endcase
    end
    if (ss_rise) begin
      if (state_n == WDATA && cnt_n == '0 && !err_n) commit = 1'b1;
      else if (state_n == WDATA || state_n == DRAIN) ferr = 1'b1;
      state_n = IDLE;
    end else if (ss_fall && state == IDLE) begin
      state_n = CMD;
      err_n   = 1'b0;
    end
  end

  // Committed registers, status pulses and the registered readback path to the slave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_word  <= '0;
      phase_word <= '0;
      enable     <= 1'b0;
      update     <= 1'b0;
      frame_err  <= 1'b0;
      spi_load   <= 1'b0;
      spi_wordin <= '0;
    end else begin
      update    <= commit;
      frame_err <= ferr;
      if (commit) begin
        case (addr_n)
          2'd0:    freq_word  <= shadow_n[FW-1:0];
          2'd1:    phase_word <= shadow_n[PW-1:0];
          default: enable     <= shadow_n[0];
        endcase
      end
      spi_load   <= (state == RDATA);
      spi_wordin <= (state == RDATA) ? rd_byte : '0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed frames through an abstract SPI slave model
// (byte-ready strobe plus parallel byte) with hand-computed expected values.
module tb_spi_cmd_decoder;

  localparam int SCLK = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss;
  logic        br;
  logic [7:0]  spi_byte;
  logic        spi_load;
  logic [7:0]  spi_wordin;
  logic [31:0] freq_word;
  logic [15:0] phase_word;
  logic        enable;
  logic        update;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int ferr_cnt = 0;
  int u0, f0;

  logic [7:0] txq [8];
  logic [7:0] rxq [8];
  logic [7:0] rb;
  logic [7:0] exp_rd [5];

  spi_cmd_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ss         (ss),
    .br         (br),
    .spi_byte   (spi_byte),
    .spi_load   (spi_load),
    .spi_wordin (spi_wordin),
    .freq_word  (freq_word),
    .phase_word (phase_word),
    .enable     (enable),
    .update     (update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count every high cycle of the status pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (update) upd_cnt = upd_cnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, output logic [7:0] rdb);
    br = 1'b0;
    #(7 * SCLK);
    spi_byte = b;
    br = 1'b1;
    #(SCLK);
    rdb = spi_wordin;
  endtask

  task automatic startFrame();
    ss = 1'b0;
    #(SCLK);
  endtask

  task automatic endFrame();
    ss = 1'b1;
    #(4 * SCLK);
  endtask

  task automatic applyStimulus(input int n);
    u0 = upd_cnt;
    f0 = ferr_cnt;
    startFrame();
    for (int i = 0; i < n; i++) sendByte(txq[i], rxq[i]);
    endFrame();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_freq"}, freq_word, 32'h0);
    checkOutput({tag, "_phase"}, 32'(phase_word), 32'h0);
    checkOutput({tag, "_enable"}, 32'(enable), 32'h0);
    checkOutput({tag, "_update"}, 32'(update), 32'h0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    checkOutput({tag, "_spi_load"}, 32'(spi_load), 32'h0);
    checkOutput({tag, "_spi_wordin"}, 32'(spi_wordin), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    ss = 1'b1;
    br = 1'b1;
    spi_byte = 8'h00;
    #32;
    checkAllZero("reset");
    rst_n = 1'b1;
    #(SCLK);

    // Frequency write
    txq = '{8'h80, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00};
    applyStimulus(5);
    checkOutput("wfreq_update", upd_cnt - u0, 1);
    checkOutput("wfreq_ferr", ferr_cnt - f0, 0);
    checkOutput("wfreq_freq", freq_word, 32'h12345678);
    checkOutput("wfreq_phase", 32'(phase_word), 32'h0);
    checkOutput("wfreq_enable", 32'(enable), 32'h0);

    // Phase write
    txq = '{8'h81, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(3);
    checkOutput("wphase_update", upd_cnt - u0, 1);
    checkOutput("wphase_phase", 32'(phase_word), 32'h0000BEEF);

    // Short write
    txq = '{8'h81, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(2);
    checkOutput("short_ferr", ferr_cnt - f0, 1);
    checkOutput("short_update", upd_cnt - u0, 0);
    checkOutput("short_phase", 32'(phase_word), 32'h0000BEEF);

    // Long write
    txq = '{8'h82, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(3);
    checkOutput("long_ferr", ferr_cnt - f0, 1);
    checkOutput("long_update", upd_cnt - u0, 0);
    checkOutput("long_enable", 32'(enable), 32'h0);

    // Frequency readback
    exp_rd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    u0 = upd_cnt;
    f0 = ferr_cnt;
    startFrame();
    sendByte(8'h00, rb);
    checkOutput("rd_load_first", 32'(spi_load), 32'h1);
    checkOutput("rd_byte0", 32'(rb), 32'(exp_rd[0]));
    for (int k = 1; k < 5; k++) begin
      sendByte(8'hFF, rb);
      checkOutput($sformatf("rd_byte%0d", k), 32'(rb), 32'(exp_rd[k]));
    end
    sendByte(8'hFF, rb);
    checkOutput("rd_load_last", 32'(spi_load), 32'h1);
    endFrame();
    checkOutput("rd_load_after", 32'(spi_load), 32'h0);
    checkOutput("rd_update", upd_cnt - u0, 0);
    checkOutput("rd_ferr", ferr_cnt - f0, 0);

    // ID read, and no capture from the idle br level at frame start
    spi_byte = 8'h00;
    ss = 1'b0;
    #(4 * SCLK);
    checkOutput("id_no_spurious", 32'(spi_load), 32'h0);
    sendByte(8'h03, rb);
    checkOutput("id_byte", 32'(rb), 32'h000000D5);
    checkOutput("id_load", 32'(spi_load), 32'h1);
    endFrame();

    // Ctrl write then ctrl readback
    txq = '{8'h82, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(2);
    checkOutput("wctrl_update", upd_cnt - u0, 1);
    checkOutput("wctrl_enable", 32'(enable), 32'h1);
    txq = '{8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(2);
    checkOutput("rctrl_byte", 32'(rxq[0]), 32'h00000001);
    checkOutput("rctrl_tail", 32'(rxq[1]), 32'h00000000);

    // Reset in the middle of a frequency write
    startFrame();
    sendByte(8'h80, rb);
    sendByte(8'hAA, rb);
    sendByte(8'hBB, rb);
    #(SCLK / 2);
    rst_n = 1'b0;
    #30;
    checkAllZero("midreset");
    rst_n = 1'b1;
    u0 = upd_cnt;
    f0 = ferr_cnt;
    sendByte(8'hCC, rb);
    sendByte(8'hDD, rb);
    checkOutput("midreset_load_in", 32'(spi_load), 32'h0);
    endFrame();
    checkOutput("midreset_update", upd_cnt - u0, 0);
    checkOutput("midreset_ferr", ferr_cnt - f0, 0);
    checkOutput("midreset_freq", freq_word, 32'h0);

    // Next full frame commits normally
    txq = '{8'h80, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h00, 8'h00, 8'h00};
    applyStimulus(5);
    checkOutput("after_update", upd_cnt - u0, 1);
    checkOutput("after_ferr", ferr_cnt - f0, 0);
    checkOutput("after_freq", freq_word, 32'hCAFEBABE);
    checkOutput("after_phase", 32'(phase_word), 32'h0);
    checkOutput("after_enable", 32'(enable), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Consumes the byte stream from the SPI slave shift stage and decodes it into DDS control registers: frequency tuning word, phase offset and enable.
- Lives in the system clock domain. Synchronises `ss` and the slave's byte-ready strobe, captures each completed byte, and runs a command/data frame FSM.
- Returns readback bytes to the slave through its parallel-load path (`wordin`/`load`).
- New register values reach the phase accumulator only on a clean frame end, signalled by a single-cycle `update`.

Parameters:
- B, 8, SPI word width in bits; must match the slave.
- FW, 32, frequency word width; multiple of B.
- PW, 16, phase offset width; multiple of B.
- ID, 8'hD5, constant returned by a read of address 3; width B.

Ports:
- clk  input  1  system clock; period < sclk period / 8.
- rst_n  input  1  asynchronous active-low reset.
- ss  input  1  SPI slave select, active low, asynchronous to clk.
- br  input  1  slave byte-ready (high while the slave bit counter is 0); sampled only while synchronised ss is low.
- spi_byte  input  B  slave parallel output (slave `wordout`); stable while br is high.
- spi_load  output  1  load request to slave (slave `load`).
- spi_wordin  output  B  readback byte to slave (slave `wordin`).
- freq_word  output  FW  committed frequency tuning word.
- phase_word  output  PW  committed phase offset.
- enable  output  1  committed DDS enable.
- update  output  1  one-clk pulse when any register commits.
- frame_err  output  1  one-clk pulse on a malformed frame.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, shadow registers 0, FSM in IDLE, sync flops loaded with ss=1 and br=1.
- Synchronisation:
  - ss and br pass through 2-flop synchronisers each; spi_byte is sampled directly, stable by the time the synced br rises.
  - Byte event = synced br rising edge while synced ss is low.
  - The slave holds br=1 at frame start before any bit arrives. On the synced ss falling edge, force the br edge-detect history to 1 so this level is not an event.
- Latency: byte captured 3 clk after the raw br rise. The spi_wordin/spi_load response is registered 1 clk later, and must land before the slave's next sclk posedge.
- Command byte:
  - bit B-1 = W (1 write, 0 read).
  - bits[1:0] = address: 0 freq (FW/B bytes), 1 phase (PW/B bytes), 2 ctrl (1 byte, bit0 = enable), 3 ID (read-only).
  - Other bits ignored.
- FSM states: IDLE, CMD, WDATA, RDATA, DRAIN.
  - IDLE -> CMD on synced ss falling edge. IDLE is only left on a falling edge, so reset mid-frame waits out the remainder of that frame.
  - CMD, byte event:
    - W=1, addr 0-2 -> WDATA; count = byte length; shadow cleared.
    - W=1, addr 3 -> DRAIN and set the error flag.
    - W=0 -> RDATA; first readback byte presented and spi_load=1.
  - WDATA: each byte event shifts the shadow left by B, inserting the byte (MSB-first), and decrements count. A byte at count 0 sets the error flag and goes to DRAIN.
  - RDATA: each byte event presents the next readback byte, MSB-first. Once the register is exhausted, spi_wordin=0. spi_load stays 1 throughout RDATA.
  - DRAIN: ignore bytes.
  - Any state, synced ss rising edge -> IDLE, with spi_load=0.
- Frame end (ss rise):
  - In WDATA with count == 0 and error flag clear: copy shadow to the target register and pulse update.
  - In WDATA with count != 0, or with the error flag set: pulse frame_err; registers unchanged.
  - From CMD (no bytes) or RDATA: no pulse.
- Simultaneous byte event and ss rise in the same clk: process the byte first, then end-of-frame evaluation on that updated state.
- Readback of addr 0-2 returns the committed value, not the shadow. ctrl reads as {B-1 zeros, enable}.
- Bytes are never lost at the required clk:sclk ratio; no back-pressure exists.

Test Plan:
- Write freq: frame 0x80,12,34,56,78 -> one update pulse after ss rise; freq_word=32'h12345678; phase_word and enable unchanged.
- Short write: frame 0x81,AB then ss high -> frame_err pulse; phase_word keeps its prior value; no update.
- Long write: frame 0x82,01,FF -> frame_err pulse, enable stays 0.
- Readback: after freq=32'h12345678, frame 0x00 then five dummy bytes -> MISO bytes 12,34,56,78,00; spi_load high only inside the frame.
- ID and frame start: read 0x03 -> first returned byte 0xD5. No spurious byte event from the initial br=1 after ss falls; check by asserting zero captures before 8 sclk edges.
- Reset mid-frame: rst_n low after 2 data bytes of a freq write -> all outputs 0. The remaining bytes of that frame have no effect; the next full frame commits normally.
